arbiter_l1_nport: RTL and testbench
===================================

Name: arbiter_l1_nport

Overview:
- Parametrised N-port arbiter between NUM_PORTS L1 caches and the single shared L2/lower-memory port.
- Each port's request is captured into a shared in-order request queue; an urgent flag gives a port precedence.
- Queued requests are issued one at a time to the lower level using a four-phase ce/RDY handshake.
- Read data and a one-cycle RDY pulse are returned to the originating port.

Parameters:
- NUM_PORTS, 2, number of L1 requesters (2..8)
- DATA_W, 32, data width
- ADDR_W, 24, address width
- QUEUE_DEPTH, 4, request queue entries (power of 2, >= NUM_PORTS)

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- data_in  in  NUM_PORTS*DATA_W  per-port write data; port p occupies bits [p*DATA_W +: DATA_W]
- addr  in  NUM_PORTS*ADDR_W  per-port address
- rw  in  NUM_PORTS  per-port direction, 1=read, 0=write
- ce  in  NUM_PORTS  per-port request; held high until that port's RDY
- pro  in  NUM_PORTS  per-port priority flag, sampled with ce
- data_out  out  NUM_PORTS*DATA_W  per-port read data, registered
- RDY  out  NUM_PORTS  per-port completion pulse, one cycle
- addr_low  out  ADDR_W  lower-level address
- data_low_out  out  DATA_W  lower-level write data
- data_low_in  in  DATA_W  lower-level read data, valid while RDY_low=1
- rw_low  out  1  lower-level direction
- ce_low  out  1  lower-level request
- RDY_low  in  1  lower-level ready

Behaviour:
- Reset: all outputs 0, queue empty, all pending bits 0, round-robin pointer 0, FSM in IDLE. Reset asserted mid-transaction aborts it: ce_low drops immediately (async) and no RDY is issued.
- Pending bit per port: set when that port is enqueued, cleared on its RDY pulse. Only ports with ce=1 and pending=0 are eligible, so each port has at most one outstanding request.
- Enqueue: at most one entry per cycle, and only when the queue is not full.
  - If any eligible port has pro=1, choose among those; otherwise choose among all eligible ports.
  - Within the chosen set, round-robin starting at rr_ptr. rr_ptr becomes (winner+1) mod NUM_PORTS.
- Entry contents: {addr, data, rw, port id}.
- Queue full: no enqueue that cycle; requesters simply keep ce high.
- Read and write pointers wrap modulo QUEUE_DEPTH. An enqueue and a dequeue in the same cycle keep the count unchanged.
- Lower FSM:
  - IDLE: if queue non-empty, load head into addr_low/data_low_out/rw_low, set ce_low=1, go to REQ.
  - REQ: wait for RDY_low=1. When seen:
    - if rw=1, data_out[id] <= data_low_in;
    - RDY[id] <= 1 for one cycle, clear pending[id], pop the queue;
    - ce_low <= 0, go to REL.
  - REL: wait for RDY_low=0, then go to IDLE.
- Latency: ce sampled at edge 0 -> enqueued; ce_low high after edge 1 (empty queue) -> RDY_low at edge k -> RDY pulse high after edge k.
- Write entries leave data_out unchanged.
- A requester dropping ce before its RDY has no effect; the captured request completes anyway.

Optional Feature:
- ARB_STATS_EN defined: adds output stat_grants (NUM_PORTS*16).
  - One saturating 16-bit counter per port, incremented on that port's RDY pulse, cleared by reset.
- Undefined: the port and the counters are absent; behaviour is otherwise identical.

Test Plan:
- Single read: port0 ce=1, rw=1, addr=0x000010; memory returns 0xDEADBEEF two cycles after ce_low -> data_out[0]=0xDEADBEEF, RDY[0] one-cycle pulse, ce_low then low.
- Simultaneous ce on ports 0 and 1, pro=0 with rr_ptr=0 -> lower issue order is port0 then port1; after reset with port1 pro=1 -> port1 is issued first.
- Write from port1: addr=0x00ABCD, data=0x12345678, rw=0 -> addr_low/data_low_out match, rw_low=0, RDY[1] pulses, data_out[1] unchanged.
- NUM_PORTS=4, QUEUE_DEPTH=4, all ports request while RDY_low is held low -> four entries queued, no duplicates, all four RDY pulses in round-robin order.
- rst_n pulled low during REQ -> ce_low=0 and RDY=0 immediately; after release the queue is empty and a new request completes normally.
- ARB_STATS_EN: three port0 transactions -> stat_grants[15:0]=3.

Source files
------------

// File: rtl/arbiter_l1_nport.sv
// N-port L1-to-L2 arbiter: per-port requests are captured into an in-order queue and issued
// one at a time over a four-phase ce/RDY handshake. Define ARB_STATS_EN to add per-port grant counters.
module arbiter_l1_nport #(
  parameter int NUM_PORTS   = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 24,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS*DATA_W-1:0]   data_in,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS-1:0]          rw,
  input  logic [NUM_PORTS-1:0]          ce,
  input  logic [NUM_PORTS-1:0]          pro,
  output logic [NUM_PORTS*DATA_W-1:0]   data_out,
  output logic [NUM_PORTS-1:0]          RDY,
  output logic [ADDR_W-1:0]             addr_low,
  output logic [DATA_W-1:0]             data_low_out,
  input  logic [DATA_W-1:0]             data_low_in,
  output logic                          rw_low,
  output logic                          ce_low,
  input  logic                          RDY_low
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]       stat_grants
`endif
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = QW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] port_addr [NUM_PORTS];
  logic [DATA_W-1:0] port_data [NUM_PORTS];

  logic [ADDR_W-1:0] q_addr [QUEUE_DEPTH];
  logic [DATA_W-1:0] q_data [QUEUE_DEPTH];
  logic              q_rw   [QUEUE_DEPTH];
  logic [PW-1:0]     q_id   [QUEUE_DEPTH];

  logic [QW-1:0]        wr_ptr_reg, wr_ptr_next;
  logic [QW-1:0]        rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [NUM_PORTS-1:0] pending_reg, pending_next;
  logic [PW-1:0]        rr_ptr_reg, rr_ptr_next;

  logic [ADDR_W-1:0]    addr_low_reg;
  logic [DATA_W-1:0]    data_low_reg;
  logic                 rw_low_reg;
  logic                 ce_low_reg;
  logic [PW-1:0]        cur_id_reg;
  logic [NUM_PORTS-1:0] rdy_reg;

  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] pro_elig;
  logic [NUM_PORTS-1:0] cand;
  logic [NUM_PORTS-1:0] win_onehot;
  logic [NUM_PORTS-1:0] done_onehot;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        scan_idx;
  logic                 win_found;
  logic                 full;
  logic                 enq;
  logic                 load_head;
  logic                 complete;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port_slice
      assign port_addr[gi] = addr[gi*ADDR_W +: ADDR_W];
      assign port_data[gi] = data_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A port still showing RDY is finishing; its ce belongs to the completed request.
  assign elig     = ce & ~pending_reg & ~rdy_reg;
  assign pro_elig = elig & pro;
  assign cand     = (|pro_elig) ? pro_elig : elig;
  assign full     = (count_reg == CW'(QUEUE_DEPTH));

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = PW'((int'(rr_ptr_reg) + i) % NUM_PORTS);
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign enq         = win_found && !full;
  assign win_onehot  = enq ? (NUM_PORTS'(1) << win_idx) : '0;
  assign done_onehot = complete ? (NUM_PORTS'(1) << cur_id_reg) : '0;

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    rr_ptr_next  = rr_ptr_reg;
    pending_next = (pending_reg | win_onehot) & ~done_onehot;
    if (enq) begin
      wr_ptr_next = wr_ptr_reg + QW'(1);
      rr_ptr_next = (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + PW'(1);
    end
    if (complete) begin
      rd_ptr_next = rd_ptr_reg + QW'(1);
    end
    case ({enq, complete})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      pending_reg <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      pending_reg <= pending_next;
      rr_ptr_reg  <= rr_ptr_next;
    end
  end

  // Queue storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[wr_ptr_reg] <= port_addr[win_idx];
      q_data[wr_ptr_reg] <= port_data[win_idx];
      q_rw[wr_ptr_reg]   <= rw[win_idx];
      q_id[wr_ptr_reg]   <= win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_head  = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (count_reg != '0) begin
          load_head  = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (RDY_low) begin
          complete   = 1'b1;
          state_next = S_REL;
        end
      end
      S_REL: begin
        if (!RDY_low) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_low_reg <= '0;
      data_low_reg <= '0;
      rw_low_reg   <= 1'b0;
      ce_low_reg   <= 1'b0;
      cur_id_reg   <= '0;
      rdy_reg      <= '0;
    end else begin
      rdy_reg <= done_onehot;
      if (load_head) begin
        addr_low_reg <= q_addr[rd_ptr_reg];
        data_low_reg <= q_data[rd_ptr_reg];
        rw_low_reg   <= q_rw[rd_ptr_reg];
        cur_id_reg   <= q_id[rd_ptr_reg];
        ce_low_reg   <= 1'b1;
      end else if (complete) begin
        ce_low_reg <= 1'b0;
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port_out
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_reg <= '0;
        end else if (complete && rw_low_reg && (cur_id_reg == PW'(gi))) begin
          rdata_reg <= data_low_in;
        end
      end

      assign data_out[gi*DATA_W +: DATA_W] = rdata_reg;

`ifdef ARB_STATS_EN
      logic [15:0] grant_cnt_reg;

      // Saturates rather than wrapping so a long run never reads back as few grants.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          grant_cnt_reg <= '0;
        end else if (rdy_reg[gi] && (grant_cnt_reg != 16'hFFFF)) begin
          grant_cnt_reg <= grant_cnt_reg + 16'd1;
        end
      end

      assign stat_grants[gi*16 +: 16] = grant_cnt_reg;
`endif
    end
  endgenerate

  assign RDY          = rdy_reg;
  assign addr_low     = addr_low_reg;
  assign data_low_out = data_low_reg;
  assign rw_low       = rw_low_reg;
  assign ce_low       = ce_low_reg;

endmodule

// File: tb/tb_arbiter_l1_nport.sv
// Self-checking bench for arbiter_l1_nport (4 ports, 4-entry queue) with a behavioural lower memory.
// Define ARB_STATS_EN to also exercise the grant counters.
module tb_arbiter_l1_nport;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int AW = 24;
  localparam int QD = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*DW-1:0]  data_in;
  logic [NP*AW-1:0]  addr;
  logic [NP-1:0]     rw;
  logic [NP-1:0]     ce;
  logic [NP-1:0]     pro;
  logic [NP*DW-1:0]  data_out;
  logic [NP-1:0]     RDY;
  logic [AW-1:0]     addr_low;
  logic [DW-1:0]     data_low_out;
  logic [DW-1:0]     data_low_in;
  logic              rw_low;
  logic              ce_low;
  logic              RDY_low;
`ifdef ARB_STATS_EN
  logic [NP*16-1:0]  stat_grants;
`endif

  always #5 clk = ~clk;

  arbiter_l1_nport #(
    .NUM_PORTS   (NP),
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .addr         (addr),
    .rw           (rw),
    .ce           (ce),
    .pro          (pro),
    .data_out     (data_out),
    .RDY          (RDY),
    .addr_low     (addr_low),
    .data_low_out (data_low_out),
    .data_low_in  (data_low_in),
    .rw_low       (rw_low),
    .ce_low       (ce_low),
    .RDY_low      (RDY_low)
`ifdef ARB_STATS_EN
    ,
    .stat_grants  (stat_grants)
`endif
  );

  typedef struct {
    int          port;
    logic        rw;
    logic        pro;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_out;
  } vec_t;

  typedef struct packed {
    logic [23:0] a;
    logic [31:0] d;
    logic        rw;
  } issue_t;

  int     pass_cnt  = 0;
  int     total_cnt = 0;
  issue_t issue_q[$];
  int     rdy_q[$];
  logic   prev_ce   = 1'b0;
  logic [NP-1:0] prev_rdy = '0;
  int     rdy_long  = 0;
  logic   mem_hold  = 1'b0;
  int     mem_lat   = 2;
  int     wait_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [23:0] a);
    return (a == 24'h000010) ? 32'hDEADBEEF : {8'hC0, a};
  endfunction

  // Lower memory: answers mem_lat cycles after ce_low, releases RDY_low once ce_low drops.
  initial begin
    RDY_low     = 1'b0;
    data_low_in = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        RDY_low  = 1'b0;
        wait_cnt = 0;
      end else if (RDY_low) begin
        if (!ce_low) RDY_low = 1'b0;
      end else if (ce_low && !mem_hold) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          RDY_low     = 1'b1;
          data_low_in = mem_rd(addr_low);
          wait_cnt    = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    issue_t r;
    if (ce_low && !prev_ce) begin
      r.a  = addr_low;
      r.d  = data_low_out;
      r.rw = rw_low;
      issue_q.push_back(r);
    end
    prev_ce = ce_low;
    if ((RDY & prev_rdy) != '0) rdy_long++;
    prev_rdy = RDY;
  end

  task automatic wait_rdys(input logic [NP-1:0] mask, input int bound, output int lat);
    logic [NP-1:0] rem;
    rem = mask;
    lat = 0;
    while (rem != '0 && lat < bound) begin
      @(negedge clk);
      lat++;
      for (int p = 0; p < NP; p++) begin
        if (RDY[p]) begin
          rdy_q.push_back(p);
          ce[p]  = 1'b0;
          pro[p] = 1'b0;
          rem[p] = 1'b0;
        end
      end
    end
    chk("rdy_all_seen", 64'(rem), 64'd0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ce       = '0;
    pro      = '0;
    rw       = '0;
    mem_hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ce_low", 64'(ce_low), 64'd0);
    chk("rst_rdy", 64'(RDY), 64'd0);
    chk("rst_addr_low", 64'(addr_low), 64'd0);
    chk("rst_data_out", 64'(|data_out), 64'd0);
    rst_n = 1'b1;
    issue_q.delete();
    rdy_q.delete();
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic r, input logic pr, input logic [23:0] a,
                         input logic [31:0] d);
    addr[p*AW +: AW]    = a;
    data_in[p*DW +: DW] = d;
    rw[p]               = r;
    pro[p]              = pr;
    ce[p]               = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int     lat;
    issue_t rec;
    issue_q.delete();
    rdy_q.delete();
    set_req(v.port, v.rw, v.pro, v.addr, v.wdata);
    wait_rdys(NP'(1) << v.port, 50, lat);
    repeat (3) @(negedge clk);
    rec = '0;
    if (issue_q.size() > 0) rec = issue_q[0];
    $display("txn %s: port %0d rw %0d addr %06h -> data_out %08h latency %0d",
             tag, v.port, v.rw, v.addr, data_out[v.port*DW +: DW], lat);
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_issue_cnt"}, 64'(issue_q.size()), 64'd1);
    chk({tag, "_addr_low"}, 64'(rec.a), 64'(v.addr));
    chk({tag, "_rw_low"}, 64'(rec.rw), 64'(v.rw));
    chk({tag, "_data_low_out"}, 64'(rec.d), 64'(v.wdata));
    chk({tag, "_data_out"}, 64'(data_out[v.port*DW +: DW]), 64'(v.exp_out));
    chk({tag, "_ce_low_idle"}, 64'(ce_low), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int     lat;
    issue_t rec;
    data_in = '0;
    addr    = '0;
    rw      = '0;
    ce      = '0;
    pro     = '0;
    rst_n   = 1'b0;

    vecs[0] = '{port: 0, rw: 1'b1, pro: 1'b0, addr: 24'h000010, wdata: 32'h11110000, exp_out: 32'hDEADBEEF};
    vecs[1] = '{port: 1, rw: 1'b0, pro: 1'b0, addr: 24'h00ABCD, wdata: 32'h12345678, exp_out: 32'h00000000};
    vecs[2] = '{port: 1, rw: 1'b1, pro: 1'b1, addr: 24'h000200, wdata: 32'h22220000, exp_out: 32'hC0000200};
    vecs[3] = '{port: 1, rw: 1'b0, pro: 1'b0, addr: 24'h00ABCE, wdata: 32'hCAFEF00D, exp_out: 32'hC0000200};
    vecs[4] = '{port: 2, rw: 1'b1, pro: 1'b0, addr: 24'h123456, wdata: 32'h33330000, exp_out: 32'hC0123456};
    vecs[5] = '{port: 3, rw: 1'b0, pro: 1'b0, addr: 24'h7FFFFF, wdata: 32'hFFFFFFFF, exp_out: 32'h00000000};
    vecs[6] = '{port: 0, rw: 1'b1, pro: 1'b0, addr: 24'hFFFFFF, wdata: 32'h44440000, exp_out: 32'hC0FFFFFF};
    vecs[7] = '{port: 3, rw: 1'b1, pro: 1'b1, addr: 24'h000000, wdata: 32'h55550000, exp_out: 32'hC0000000};

    do_reset();
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Equal priority, rr_ptr at 0 after reset: port0 then port1.
    do_reset();
    set_req(0, 1'b1, 1'b0, 24'h000100, 32'h0);
    set_req(1, 1'b1, 1'b0, 24'h000101, 32'h0);
    wait_rdys(4'b0011, 60, lat);
    repeat (3) @(negedge clk);
    $display("txn rr_pair: issues %0d completions %0d", issue_q.size(), rdy_q.size());
    rec = '0;
    if (issue_q.size() > 0) rec = issue_q[0];
    chk("rr_first_addr", 64'(rec.a), 64'h000100);
    chk("rr_first_port", 64'((rdy_q.size() > 0) ? rdy_q[0] : 99), 64'd0);
    chk("rr_second_port", 64'((rdy_q.size() > 1) ? rdy_q[1] : 99), 64'd1);

    // Urgent port1 beats port0 even though rr_ptr points at port0.
    do_reset();
    set_req(0, 1'b1, 1'b0, 24'h000100, 32'h0);
    set_req(1, 1'b1, 1'b1, 24'h000101, 32'h0);
    wait_rdys(4'b0011, 60, lat);
    repeat (3) @(negedge clk);
    $display("txn pro_pair: issues %0d completions %0d", issue_q.size(), rdy_q.size());
    rec = '0;
    if (issue_q.size() > 0) rec = issue_q[0];
    chk("pro_first_addr", 64'(rec.a), 64'h000101);
    chk("pro_first_port", 64'((rdy_q.size() > 0) ? rdy_q[0] : 99), 64'd1);
    chk("pro_second_port", 64'((rdy_q.size() > 1) ? rdy_q[1] : 99), 64'd0);
    chk("pro_data_out1", 64'(data_out[1*DW +: DW]), 64'hC0000101);

    // All four ports queue up while the memory stalls, then drain in round-robin order.
    do_reset();
    mem_hold = 1'b1;
    for (int p = 0; p < NP; p++) set_req(p, 1'b1, 1'b0, 24'h000400 + 24'(p), 32'h0);
    repeat (8) @(negedge clk);
    chk("full_ce_low_held", 64'(ce_low), 64'd1);
    chk("full_head_addr", 64'(addr_low), 64'h000400);
    chk("full_no_rdy", 64'(RDY), 64'd0);
    mem_hold = 1'b0;
    wait_rdys(4'b1111, 200, lat);
    repeat (6) @(negedge clk);
    $display("txn four_port: issues %0d completions %0d", issue_q.size(), rdy_q.size());
    chk("four_issue_cnt", 64'(issue_q.size()), 64'd4);
    chk("four_rdy_cnt", 64'(rdy_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      rec = '0;
      if (i < issue_q.size()) rec = issue_q[i];
      chk($sformatf("four_order_%0d", i), 64'((i < rdy_q.size()) ? rdy_q[i] : 99), 64'(i));
      chk($sformatf("four_addr_%0d", i), 64'(rec.a), 64'(24'h000400 + 24'(i)));
      chk($sformatf("four_data_out_%0d", i), 64'(data_out[i*DW +: DW]), 64'(32'hC0000400 + 32'(i)));
    end

    // Reset in the middle of a stalled request aborts it immediately.
    do_reset();
    mem_hold = 1'b1;
    set_req(0, 1'b1, 1'b0, 24'h000500, 32'h0);
    repeat (3) @(negedge clk);
    chk("abort_ce_low_before", 64'(ce_low), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ce_low_async", 64'(ce_low), 64'd0);
    chk("abort_rdy_async", 64'(RDY), 64'd0);
    ce       = '0;
    pro      = '0;
    mem_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("txn abort: reset applied during REQ");
    run_vec('{port: 1, rw: 1'b1, pro: 1'b0, addr: 24'h000300, wdata: 32'h0, exp_out: 32'hC0000300},
            "post_abort");
    chk("post_abort_data_out0", 64'(data_out[0 +: DW]), 64'd0);

`ifdef ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) run_vec(vecs[0], $sformatf("stat%0d", i));
    repeat (2) @(negedge clk);
    chk("stat_port0", 64'(stat_grants[15:0]), 64'd3);
    chk("stat_port1", 64'(stat_grants[31:16]), 64'd0);
`endif

    chk("rdy_single_cycle", 64'(rdy_long), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
